// File: rtl/cam_i2c_pkg.sv
// Shared definitions for the camera sensor init sequencer: entry layout,
// opcodes, FSM encoding and the OV5647 bus address.
package cam_i2c_pkg;

  localparam int ENTRY_W  = 26;
  localparam int OP_MSB   = 25;
  localparam int OP_LSB   = 24;
  localparam int REG_MSB  = 23;
  localparam int REG_LSB  = 8;
  localparam int VAL_MSB  = 7;
  localparam int VAL_LSB  = 0;
  localparam int TICK_MSB = 15;
  localparam int TICK_LSB = 0;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  localparam logic [6:0] OV5647_ADDR = 7'h36;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_CMD, S_D_HI, S_D_LO, S_D_VAL,
    S_WAIT_BUS, S_DELAY, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  function automatic logic [ENTRY_W-1:0] ent_write(input logic [15:0] r, input logic [7:0] v);
    return {OP_WRITE, r, v};
  endfunction

  function automatic logic [ENTRY_W-1:0] ent_delay(input logic [15:0] t);
    return {OP_DELAY, 8'h00, t};
  endfunction

  function automatic logic [ENTRY_W-1:0] ent_end();
    return {OP_END, 24'h000000};
  endfunction

endpackage

// File: rtl/cam_init_rom.sv
// Sensor power-up configuration table; one-cycle registered read.
module cam_init_rom
  import cam_i2c_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic [IDX_W-1:0]   addr,
  output logic [ENTRY_W-1:0] entry
);

  always_ff @(posedge clk) begin
    case (addr)
      IDX_W'(0): entry <= ent_write(16'h0100, 8'h00);  // stream off
      IDX_W'(1): entry <= ent_write(16'h0103, 8'h01);  // software reset
      IDX_W'(2): entry <= ent_delay(16'd2);
      IDX_W'(3): entry <= ent_write(16'h3034, 8'h1A);
      IDX_W'(4): entry <= ent_end();
      default:   entry <= ent_end();
    endcase
  end

endmodule

// File: rtl/cam_i2c_init_seq.sv
// Walks the sensor init table and drives i2c_master's command/data streams.
// Optional macro CAM_INIT_RETRY_EN: re-issue a NACKed entry up to RETRY_MAX times.
module cam_i2c_init_seq
  import cam_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = OV5647_ADDR,
  parameter int         TABLE_DEPTH = 64,
  parameter int         DELAY_UNIT  = 25000,
`ifdef CAM_INIT_RETRY_EN
  parameter int         RETRY_MAX   = 3,
`endif
  localparam int        IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [6:0]       cmd_address,
  output logic             cmd_start,
  output logic             cmd_read,
  output logic             cmd_write,
  output logic             cmd_write_multiple,
  output logic             cmd_stop,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       data_in,
  output logic             data_in_valid,
  input  logic             data_in_ready,
  output logic             data_in_last,
  input  logic             i2c_busy,
  input  logic             missed_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  localparam int DLY_W = 16 + $clog2(DELAY_UNIT + 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     index, index_nxt;
  logic [ENTRY_W-1:0]   entry;
  logic [DLY_W-1:0]     dly_cnt, dly_load;
  logic                 nack, nack_any;
  logic                 bus_seen, wait_min, bus_done;
  logic                 start_acc;
  logic [15:0]          ticks;
`ifdef CAM_INIT_RETRY_EN
  localparam int RTY_W = $clog2(RETRY_MAX + 1);
  logic [RTY_W-1:0]     retry_cnt;
`endif

  assign cmd_address = DEV_ADDR;
  assign cmd_start   = 1'b0;
  assign cmd_read    = 1'b0;
  assign cmd_write   = 1'b0;

  // ROM is addressed with the next index so the entry is valid in FETCH
  cam_init_rom #(.IDX_W(IDX_W)) u_rom (
    .clk   (clk),
    .addr  (index_nxt),
    .entry (entry)
  );

  assign ticks     = entry[TICK_MSB:TICK_LSB];
  assign dly_load  = (ticks == 16'd0) ? DLY_W'(1) : DLY_W'(ticks) * DLY_W'(DELAY_UNIT);
  assign nack_any  = nack | missed_ack;
  assign bus_done  = !i2c_busy && (bus_seen || wait_min);
  assign start_acc = start && (state == S_IDLE || state == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      S_IDLE, S_ERROR: begin
        if (start) begin
          state_nxt = S_FETCH;
          index_nxt = '0;
        end
      end
      S_FETCH: begin
        case (entry[OP_MSB:OP_LSB])
          OP_WRITE: state_nxt = S_CMD;
          OP_DELAY: state_nxt = S_DELAY;
          default:  state_nxt = S_FINISH;
        endcase
      end
      S_CMD:   if (cmd_ready)     state_nxt = S_D_HI;
      S_D_HI:  if (data_in_ready) state_nxt = S_D_LO;
      S_D_LO:  if (data_in_ready) state_nxt = S_D_VAL;
      S_D_VAL: if (data_in_ready) state_nxt = S_WAIT_BUS;
      S_WAIT_BUS: begin
        if (bus_done) begin
          if (nack_any) begin
`ifdef CAM_INIT_RETRY_EN
            state_nxt = (retry_cnt < RTY_W'(RETRY_MAX)) ? S_CMD : S_ERROR;
`else
            state_nxt = S_ERROR;
`endif
          end else begin
            state_nxt = S_NEXT;
          end
        end
      end
      S_DELAY: if (dly_cnt <= DLY_W'(1)) state_nxt = S_NEXT;
      S_NEXT: begin
        if (index == IDX_W'(TABLE_DEPTH - 1)) begin
          state_nxt = S_FINISH;
        end else begin
          index_nxt = index + 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and datapath, all decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index              <= '0;
      cmd_valid          <= 1'b0;
      cmd_write_multiple <= 1'b0;
      cmd_stop           <= 1'b0;
      data_in_valid      <= 1'b0;
      data_in_last       <= 1'b0;
      data_in            <= 8'h00;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_index          <= '0;
      dly_cnt            <= '0;
      nack               <= 1'b0;
      bus_seen           <= 1'b0;
      wait_min           <= 1'b0;
    end else begin
      index              <= index_nxt;
      cmd_valid          <= (state_nxt == S_CMD);
      cmd_write_multiple <= (state_nxt == S_CMD);
      cmd_stop           <= (state_nxt == S_CMD);
      data_in_valid      <= (state_nxt inside {S_D_HI, S_D_LO, S_D_VAL});
      data_in_last       <= (state_nxt == S_D_VAL);
      busy               <= !(state_nxt inside {S_IDLE, S_FINISH, S_ERROR});
      case (state_nxt)
        S_D_HI:  data_in <= entry[REG_MSB:REG_MSB-7];
        S_D_LO:  data_in <= entry[REG_LSB+7:REG_LSB];
        S_D_VAL: data_in <= entry[VAL_MSB:VAL_LSB];
        default: data_in <= data_in;
      endcase
      if (start_acc) begin
        done  <= 1'b0;
        error <= 1'b0;
      end else if (state_nxt == S_FINISH) begin
        done <= 1'b1;
      end else if (state_nxt == S_ERROR && state != S_ERROR) begin
        error     <= 1'b1;
        err_index <= index;
      end
      if (state == S_FETCH && state_nxt == S_DELAY) dly_cnt <= dly_load;
      else if (state == S_DELAY)                   dly_cnt <= dly_cnt - 1'b1;
      // NACK is sticky per attempt; a fresh command attempt clears it
      if (state_nxt == S_CMD && state != S_CMD) nack <= 1'b0;
      else if (missed_ack && state inside {S_CMD, S_D_HI, S_D_LO, S_D_VAL, S_WAIT_BUS}) nack <= 1'b1;
      if (state == S_WAIT_BUS) begin
        bus_seen <= bus_seen | i2c_busy;
        wait_min <= 1'b1;
      end else begin
        bus_seen <= 1'b0;
        wait_min <= 1'b0;
      end
    end
  end

`ifdef CAM_INIT_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          retry_cnt <= '0;
    else if (start_acc || state == S_NEXT)            retry_cnt <= '0;
    else if (state == S_WAIT_BUS && state_nxt == S_CMD) retry_cnt <= retry_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_cam_i2c_init_seq.sv
// Directed bench for cam_i2c_init_seq against a small i2c_master model.
module tb_cam_i2c_init_seq
  import cam_i2c_pkg::*;
;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [7:0] data_in;
  logic       data_in_valid, data_in_last;
  logic       data_in_ready = 1'b1;
  logic       i2c_busy = 1'b0;
  logic       missed_ack = 1'b0;
  logic       busy, done, error;
  logic [5:0] err_index;

  int n_checks = 0;
  int n_errors = 0;

  // model state (written only by the model process)
  int         cmd_cnt = 0, byte_cnt = 0, cmd_bad = 0, stab_err = 0;
  int         dly_cyc = 0, dly_bad = 0;
  int         cmd_wait = 0, dat_wait = 0, busy_tail = 0;
  logic       cmd_hs_q = 1'b0, dat_hs_q = 1'b0;
  logic       prev_cv = 1'b0, prev_dv = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] byte_log [0:255];
  // model controls (written only by the stimulus process)
  int         bp = 0, nack_first = 0, nack_n = 0;

  logic [8:0] exp_b [0:8] = '{9'h001, 9'h000, 9'h100, 9'h001, 9'h003, 9'h101,
                              9'h030, 9'h034, 9'h11A};

  always #5 clk = ~clk;

  cam_i2c_init_seq #(.DELAY_UNIT(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_in_last(data_in_last), .i2c_busy(i2c_busy), .missed_ack(missed_ack),
    .busy(busy), .done(done), .error(error), .err_index(err_index)
  );

  // i2c_master model: records handshakes decided on the previous falling edge
  always @(negedge clk) begin
    if (rst) begin
      cmd_hs_q = 1'b0; dat_hs_q = 1'b0; i2c_busy = 1'b0; busy_tail = 0;
      missed_ack = 1'b0; cmd_wait = 0; dat_wait = 0; prev_cv = 1'b0; prev_dv = 1'b0;
    end else begin
      missed_ack = 1'b0;
      if (prev_cv && !cmd_hs_q && !cmd_valid) stab_err++;
      if (prev_dv && !dat_hs_q &&
          (!data_in_valid || data_in !== prev_data || data_in_last !== prev_last)) stab_err++;
      if (cmd_hs_q) begin
        cmd_cnt++;
        i2c_busy = 1'b1;
      end
      if (dat_hs_q) begin
        if (byte_cnt < 256) byte_log[byte_cnt] = {prev_last, prev_data};
        byte_cnt++;
        if (prev_last) begin
          busy_tail = 3;
          if (cmd_cnt >= nack_first && cmd_cnt < nack_first + nack_n) missed_ack = 1'b1;
        end
      end else if (busy_tail > 0) begin
        busy_tail--;
        if (busy_tail == 0) i2c_busy = 1'b0;
      end
      if (dut.state == S_DELAY) begin
        dly_cyc++;
        if (cmd_valid || data_in_valid) dly_bad++;
      end
      if (cmd_valid) begin
        if (cmd_wait >= bp) begin cmd_ready = 1'b1; cmd_wait = 0; end
        else begin cmd_ready = 1'b0; cmd_wait++; end
      end else cmd_ready = (bp == 0);
      if (data_in_valid) begin
        if (dat_wait >= bp) begin data_in_ready = 1'b1; dat_wait = 0; end
        else begin data_in_ready = 1'b0; dat_wait++; end
      end else data_in_ready = (bp == 0);
      cmd_hs_q = cmd_valid && cmd_ready;
      dat_hs_q = data_in_valid && data_in_ready;
      if (cmd_hs_q && (cmd_address !== 7'h36 || cmd_write_multiple !== 1'b1 || cmd_stop !== 1'b1 ||
                       cmd_read !== 1'b0 || cmd_write !== 1'b0 || cmd_start !== 1'b0)) cmd_bad++;
      prev_cv = cmd_valid; prev_dv = data_in_valid;
      prev_data = data_in; prev_last = data_in_last;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_vld"}, {cmd_valid, data_in_valid, data_in_last}, 32'h0);
    check_val({tag, "_ctl"}, {cmd_write_multiple, cmd_stop}, 32'h0);
    check_val({tag, "_sts"}, {busy, done, error}, 32'h0);
    check_val({tag, "_dat"}, {err_index, data_in}, 32'h0);
  endtask

  initial begin
    bit ok;
    int cb, bb, db;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst0");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full table, no backpressure
    cb = cmd_cnt; bb = byte_cnt; db = dly_cyc;
    pulse_start();
    check_val("t1_busy", busy, 1);
    wait_end(2000, ok);
    check_val("t1_end", ok, 1);
    check_val("t1_sts", {busy, done, error}, 3'b010);
    check_val("t1_ncmd", cmd_cnt - cb, 3);
    check_val("t1_nbyte", byte_cnt - bb, 9);
    for (int k = 0; k < 9; k++) check_val($sformatf("t1_b%0d", k), byte_log[bb + k], exp_b[k]);
    check_val("t1_dly", dly_cyc - db, 20);
    check_val("t1_dly_vld", dly_bad, 0);
    check_val("t1_cmdf", cmd_bad, 0);

    // backpressure plus an ignored start while busy
    bp = 5; cb = cmd_cnt; bb = byte_cnt;
    pulse_start();
    for (int i = 0; i < 500 && cmd_cnt == cb; i++) @(negedge clk);
    pulse_start();
    wait_end(4000, ok);
    check_val("t2_end", ok, 1);
    check_val("t2_sts", {busy, done, error}, 3'b010);
    check_val("t2_ncmd", cmd_cnt - cb, 3);
    check_val("t2_nbyte", byte_cnt - bb, 9);
    for (int k = 0; k < 9; k++) check_val($sformatf("t2_b%0d", k), byte_log[bb + k], exp_b[k]);
    check_val("t2_stable", stab_err, 0);
    bp = 0;

`ifdef CAM_INIT_RETRY_EN
    // two NACKs on entry 1 recover via retry
    cb = cmd_cnt; nack_first = cb + 2; nack_n = 2;
    pulse_start();
    wait_end(3000, ok);
    check_val("t3r_end", ok, 1);
    check_val("t3r_sts", {busy, done, error}, 3'b010);
    check_val("t3r_ncmd", cmd_cnt - cb, 5);
    // four NACKs exhaust the retries
    cb = cmd_cnt; nack_first = cb + 2; nack_n = 4;
    pulse_start();
    wait_end(3000, ok);
    repeat (50) @(negedge clk);
    check_val("t3e_end", ok, 1);
    check_val("t3e_sts", {busy, done, error}, 3'b001);
    check_val("t3e_idx", err_index, 1);
    check_val("t3e_ncmd", cmd_cnt - cb, 5);
    nack_n = 0;
`else
    // single NACK on entry 1 aborts
    cb = cmd_cnt; nack_first = cb + 2; nack_n = 1;
    pulse_start();
    wait_end(3000, ok);
    repeat (50) @(negedge clk);
    check_val("t3_end", ok, 1);
    check_val("t3_sts", {busy, done, error}, 3'b001);
    check_val("t3_idx", err_index, 1);
    check_val("t3_ncmd", cmd_cnt - cb, 2);
    nack_n = 0;
`endif

    // reset while the second byte is offered, then replay from entry 0
    bp = 3; bb = byte_cnt;
    pulse_start();
    for (int i = 0; i < 500 && !(byte_cnt == bb + 1 && data_in_valid); i++) @(negedge clk);
    check_val("t4_in_dlo", {data_in_valid, data_in_last, data_in}, 10'h200);
    #2 rst = 1'b1;
    #1 check_idle_outputs("t4_rst");
    bp = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bb = byte_cnt;
    pulse_start();
    wait_end(2000, ok);
    check_val("t4_end", ok, 1);
    check_val("t4_sts", {busy, done, error}, 3'b010);
    for (int k = 0; k < 3; k++) check_val($sformatf("t4_b%0d", k), byte_log[bb + k], exp_b[k]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cam_i2c_init_seq.md
Name: cam_i2c_init_seq

Overview:
Sequences the camera sensor's power-up register configuration over the existing i2c_master command/data stream interface. Walks an internal table of 16-bit-register / 8-bit-data writes and timed delays. Issues one write-multiple+stop command plus three data bytes per entry. Reports done or error. Sits between top-level reset/start logic and i2c_master.

Parameters:
DEV_ADDR, 7'h36, 7-bit I2C sensor address placed on cmd_address.
TABLE_DEPTH, 64, number of table entries; index width IDX_W = $clog2(TABLE_DEPTH).
DELAY_UNIT, 25000, clk cycles per delay tick (1 ms at 25 MHz).
RETRY_MAX, 3, retries per entry (only with CAM_INIT_RETRY_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse, begins sequence from entry 0 (ignored unless IDLE/DONE/ERROR)
cmd_address  out  7  to i2c_master, constant DEV_ADDR
cmd_start / cmd_read / cmd_write / cmd_stop  out  1 each  to i2c_master; cmd_read, cmd_write, cmd_start always 0
cmd_write_multiple  out  1  to i2c_master
cmd_valid  out  1  command valid
cmd_ready  in  1  command accepted
data_in  out  8  write byte to i2c_master
data_in_valid  out  1  byte valid
data_in_ready  in  1  byte accepted
data_in_last  out  1  final byte of the transfer
i2c_busy  in  1  i2c_master busy
missed_ack  in  1  i2c_master NACK pulse
busy  out  1  sequence in progress
done  out  1  level, table completed without error
error  out  1  level, aborted on NACK
err_index  out  IDX_W  entry index that failed

Behaviour:
- Reset (async, any state): state IDLE; all valid outputs, cmd_write_multiple, cmd_stop, data_in_last, busy, done, error at 0; data_in 0; err_index 0; index 0.
- Entry format is 26 bits, op[25:24]:
  - 00 WRITE {reg[23:8], val[7:0]}
  - 01 DELAY {ticks[15:0]}
  - 10 END
  - 11 reserved, treated as END
- ROM read is registered, so entries arrive 1 cycle after the index is applied.
- FSM:
  - IDLE: on start, set index=0, busy=1, clear done/error; go FETCH.
  - FETCH: 1 cycle; decode op; go CMD, DELAY, or FINISH.
  - CMD: assert cmd_valid with cmd_write_multiple=1, cmd_stop=1; hold stable until cmd_ready; transfer on the cycle where valid and ready are both high; go D_HI.
  - D_HI, D_LO, D_VAL: assert data_in_valid with reg[15:8], reg[7:0], then val; data_in_last=1 only in D_VAL; advance only on data_in_ready; after D_VAL go WAIT_BUS.
  - WAIT_BUS: wait for i2c_busy to be seen high and then low (or 2-cycle minimum if already low); go NEXT.
  - DELAY: count ticks*DELAY_UNIT cycles; ticks=0 means 1 cycle; go NEXT.
  - NEXT: index++. If index == TABLE_DEPTH-1 before increment, go FINISH; otherwise go FETCH.
  - FINISH: busy=0, done=1; go IDLE.
  - ERROR: busy=0, error=1; hold until start or rst.
- missed_ack sampled in any of CMD…WAIT_BUS sets a sticky nack flag. At the end of WAIT_BUS, nack=1 causes err_index<=index and a move to ERROR.
- start while busy is ignored.
- Outputs are registered. Valid is never deasserted before ready. Data is stable while valid is high.

Optional Feature:
CAM_INIT_RETRY_EN:
- Defined: on NACK, if retry count < RETRY_MAX, increment it and re-enter CMD for the same entry. The count resets on each NEXT. ERROR is entered only after RETRY_MAX+1 failed attempts.
- Undefined: the first NACK goes straight to ERROR; no retry counter is synthesized.

Decomposition:
- Shared package cam_i2c_pkg: OP_WRITE/OP_DELAY/OP_END localparams, the 26-bit entry field positions, the state encoding, and OV5647 DEV_ADDR.
- One sub-module, cam_init_rom: index in, registered 26-bit entry out, case-statement table ending in OP_END.
- The FSM, delay counter and retry counter stay in cam_i2c_init_seq.

Test Plan:
- Table {WRITE 0x0100=0x00, WRITE 0x0103=0x01, END}; i2c model ready always and acking. Expected: two commands with cmd_address=0x36 and bytes 01,00,00 then 01,03,01, data_in_last on the 3rd byte only; done=1 and busy=0 afterwards.
- Backpressure: cmd_ready and data_in_ready held low 5 cycles each. Expected: valids held and data stable; no byte duplicated or dropped.
- DELAY ticks=2, DELAY_UNIT=10. Expected: exactly 20 cycles in DELAY, with no cmd_valid and no data_in_valid asserted.
- missed_ack pulsed on entry 1 (macro undefined). Expected: error=1, err_index=1, done=0, and no entry-2 command issued.
- CAM_INIT_RETRY_EN with 2 NACKs, then an ack. Expected: 3 command attempts for that entry, then done=1. With 4 NACKs: error=1.
- rst asserted mid-D_LO. Expected: all outputs 0 immediately. A later start replays from entry 0.
